// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package inst_fetch_unit_pkg;

    localparam int unsigned INSTR_W           = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_t;

    // True when a byte PC is word aligned and indexes inside the instruction memory.
    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < words);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory bus: word address out, combinational instruction word back.
interface inst_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);

endinterface

// File: rtl/inst_fetch_unit_if_id_reg.sv
// IF/ID stage register: load captures a new word, flush clears only valid, otherwise hold.
module if_id_reg
    import inst_fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] next_instr,
    input  logic [31:0]        next_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= next_instr;
            pc       <= next_pc;
            pc_plus4 <= next_pc + PC_STEP;
            valid    <= 1'b1;
        end else if (flush) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch initiator: PC, boot delay, redirect/stall/halt control and address-fault trap.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0]        RESET_PC    = 32'h0000_0000,
    parameter int unsigned        MEM_WORDS   = 256,
    parameter int unsigned        BOOT_CYCLES = 4,
    parameter logic [INSTR_W-1:0] HALT_WORD   = HALT_WORD_DEFAULT
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  resume,
    inst_fetch_unit_if.master     imem,
    output logic [INSTR_W-1:0]    if_instr,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc_plus4,
    output logic                  if_valid,
    output logic                  halted,
    output logic                  fault
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4;
    logic [7:0]   boot_cnt;
    logic         redirect_ok, seq_ok, is_halt;
    logic         load, flush;

    assign pc_plus4       = pc + PC_STEP;
    assign imem.imem_addr = {2'b00, pc[31:2]};
    assign redirect_ok    = pc_in_range(redirect_pc, MEM_WORDS);
    assign seq_ok         = pc_in_range(pc_plus4, MEM_WORDS);
    assign is_halt        = (imem.imem_instr == HALT_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            boot_cnt <= 8'(BOOT_CYCLES);
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == ST_BOOT)
                boot_cnt <= boot_cnt - 8'd1;
        end
    end

    // A sequential overrun outranks a halt word in the same latch: the trap wins.
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: begin
                if (boot_cnt <= 8'd1)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid)
                    state_next = redirect_ok ? ST_RUN : ST_FAULT;
                else if (!stall) begin
                    if (!seq_ok)
                        state_next = ST_FAULT;
                    else if (is_halt)
                        state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (redirect_valid)
                    state_next = redirect_ok ? ST_RUN : ST_FAULT;
                else if (resume)
                    state_next = ST_RUN;
            end
            ST_FAULT: state_next = ST_FAULT;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        flush   = 1'b0;
        pc_next = pc;
        case (state)
            ST_BOOT: ;
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_ok)
                        pc_next = redirect_pc;
                end else if (!stall) begin
                    load = 1'b1;
                    if (seq_ok)
                        pc_next = pc_plus4;
                end
            end
            ST_HALTED: begin
                flush = 1'b1;
                if (redirect_valid && redirect_ok)
                    pc_next = redirect_pc;
            end
            ST_FAULT: flush = 1'b1;
        endcase
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .flush      (flush),
        .next_instr (imem.imem_instr),
        .next_pc    (pc),
        .instr      (if_instr),
        .pc         (if_pc),
        .pc_plus4   (if_pc_plus4),
        .valid      (if_valid)
    );

    assign halted = (state == ST_HALTED);
    assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed table-driven bench for inst_fetch_unit with a small instruction-memory model.
module tb_inst_fetch_unit;

    localparam logic [31:0] H  = 32'hFFFF_FFFF;
    localparam int unsigned NV = 29;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        resume;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        halted;
        logic        fault;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;
    logic        fault;

    logic [31:0] mem [256];
    int          checks;
    int          errors;
    vec_t        vecs [NV];

    inst_fetch_unit_if imem_bus ();

    inst_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .MEM_WORDS   (256),
        .BOOT_CYCLES (4),
        .HALT_WORD   (32'hFFFF_FFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .imem           (imem_bus.master),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_valid       (if_valid),
        .halted         (halted),
        .fault          (fault)
    );

    always_comb begin
        imem_bus.imem_instr = 32'hDEAD_BEEF;
        if (imem_bus.imem_addr < 32'd256)
            imem_bus.imem_instr = mem[imem_bus.imem_addr[7:0]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic res, input logic [31:0] addr, input logic v,
                                input logic [31:0] ipc, input logic [31:0] ins,
                                input logic h, input logic f);
        vec_t r;
        r.stall = s;  r.rv = rv;  r.rpc = rpc;  r.resume = res;
        r.addr = addr; r.valid = v; r.ipc = ipc; r.instr = ins;
        r.halted = h; r.fault = f;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic rv, input logic [31:0] rpc, input logic res);
        stall = s; redirect_valid = rv; redirect_pc = rpc; resume = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] addr, input logic v,
                              input logic [31:0] ipc, input logic [31:0] ins,
                              input logic h, input logic f);
        check({tag, ".addr"},   imem_bus.imem_addr, addr);
        check({tag, ".valid"},  {31'd0, if_valid}, {31'd0, v});
        check({tag, ".pc"},     if_pc, ipc);
        check({tag, ".instr"},  if_instr, ins);
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
        check({tag, ".fault"},  {31'd0, fault}, {31'd0, f});
    endtask

    // Called at posedge+1: assert reset between edges, check the async clear, release before the next edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check_outs(tag, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check({tag, ".pc4"}, if_pc_plus4, 32'd0);
        #3 rst = 1'b0;
    endtask

    task automatic boot_wait(input string tag);
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            check($sformatf("%s.boot%0d.valid", tag, k), {31'd0, if_valid}, 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        set_in(1'b0, 1'b0, 32'd0, 1'b0);
        for (int unsigned k = 0; k < 256; k++) mem[k] = k;
        mem[5] = H;

        //            stall rv  rpc     res  addr    v   ipc     instr  h  f
        vecs[0]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h00, 32'h00, 0, 0);
        vecs[1]  = mk(1, 1, 32'h40, 1, 32'h00, 0, 32'h00, 32'h00, 0, 0);
        vecs[2]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h00, 32'h00, 0, 0);
        vecs[3]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h00, 32'h00, 0, 0);
        vecs[4]  = mk(0, 0, 32'h00, 0, 32'h01, 1, 32'h00, 32'h00, 0, 0);
        vecs[5]  = mk(0, 0, 32'h00, 0, 32'h02, 1, 32'h04, 32'h01, 0, 0);
        vecs[6]  = mk(0, 0, 32'h00, 0, 32'h03, 1, 32'h08, 32'h02, 0, 0);
        vecs[7]  = mk(1, 0, 32'h00, 0, 32'h03, 1, 32'h08, 32'h02, 0, 0);
        vecs[8]  = mk(1, 0, 32'h00, 0, 32'h03, 1, 32'h08, 32'h02, 0, 0);
        vecs[9]  = mk(1, 0, 32'h00, 0, 32'h03, 1, 32'h08, 32'h02, 0, 0);
        vecs[10] = mk(0, 0, 32'h00, 0, 32'h04, 1, 32'h0C, 32'h03, 0, 0);
        vecs[11] = mk(1, 1, 32'h40, 0, 32'h10, 0, 32'h0C, 32'h03, 0, 0);
        vecs[12] = mk(0, 0, 32'h00, 0, 32'h11, 1, 32'h40, 32'h10, 0, 0);
        vecs[13] = mk(0, 1, 32'h10, 0, 32'h04, 0, 32'h40, 32'h10, 0, 0);
        vecs[14] = mk(0, 0, 32'h00, 0, 32'h05, 1, 32'h10, 32'h04, 0, 0);
        vecs[15] = mk(0, 0, 32'h00, 0, 32'h06, 1, 32'h14, H,      1, 0);
        vecs[16] = mk(0, 0, 32'h00, 0, 32'h06, 0, 32'h14, H,      1, 0);
        vecs[17] = mk(1, 0, 32'h00, 0, 32'h06, 0, 32'h14, H,      1, 0);
        vecs[18] = mk(0, 0, 32'h00, 1, 32'h06, 0, 32'h14, H,      0, 0);
        vecs[19] = mk(0, 0, 32'h00, 0, 32'h07, 1, 32'h18, 32'h06, 0, 0);
        vecs[20] = mk(0, 1, 32'h14, 0, 32'h05, 0, 32'h18, 32'h06, 0, 0);
        vecs[21] = mk(0, 0, 32'h00, 0, 32'h06, 1, 32'h14, H,      1, 0);
        vecs[22] = mk(0, 1, 32'h40, 1, 32'h10, 0, 32'h14, H,      0, 0);
        vecs[23] = mk(0, 0, 32'h00, 0, 32'h11, 1, 32'h40, 32'h10, 0, 0);
        vecs[24] = mk(0, 1, 32'h42, 0, 32'h11, 0, 32'h40, 32'h10, 0, 1);
        vecs[25] = mk(0, 1, 32'h40, 0, 32'h11, 0, 32'h40, 32'h10, 0, 1);
        vecs[26] = mk(0, 0, 32'h00, 1, 32'h11, 0, 32'h40, 32'h10, 0, 1);
        vecs[27] = mk(1, 0, 32'h00, 0, 32'h11, 0, 32'h40, 32'h10, 0, 1);
        vecs[28] = mk(0, 0, 32'h00, 0, 32'h11, 0, 32'h40, 32'h10, 0, 1);

        #22;
        rst = 1'b0;
        #1;
        check_outs("reset", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("reset.pc4", if_pc_plus4, 32'd0);

        for (int unsigned i = 0; i < NV; i++) begin
            set_in(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].resume);
            tick();
            check_outs($sformatf("v%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].ipc,
                       vecs[i].instr, vecs[i].halted, vecs[i].fault);
            check($sformatf("v%0d.pc4", i), if_pc_plus4, (i < 4) ? 32'd0 : vecs[i].ipc + 32'd4);
        end
        set_in(1'b0, 1'b0, 32'd0, 1'b0);

        // Fault clears only through reset; then reset again in the middle of RUN.
        do_reset("rst_fault");
        boot_wait("rst_fault");
        tick();
        check_outs("rb1", 32'd1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        check_outs("rb2", 32'd2, 1'b1, 32'd4, 32'd1, 1'b0, 1'b0);
        do_reset("rst_run");
        boot_wait("rst_run");
        tick();
        check_outs("rb3", 32'd1, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);

        // Redirect range boundary: last word accepted, one past traps.
        set_in(1'b0, 1'b1, 32'h3FC, 1'b0);
        tick();
        check_outs("rd_last", 32'd255, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 32'h400, 1'b0);
        tick();
        check_outs("rd_over", 32'd255, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        set_in(1'b0, 1'b0, 32'd0, 1'b0);

        // Sequential run off the end of memory.
        do_reset("rst_seq");
        boot_wait("rst_seq");
        set_in(1'b0, 1'b1, 32'h3F8, 1'b0);
        tick();
        check_outs("sq0", 32'd254, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        check_outs("sq1", 32'd255, 1'b1, 32'h3F8, 32'd254, 1'b0, 1'b0);
        tick();
        check_outs("sq2", 32'd255, 1'b1, 32'h3FC, 32'd255, 1'b0, 1'b1);
        check("sq2.pc4", if_pc_plus4, 32'h400);
        tick();
        check_outs("sq3", 32'd255, 1'b0, 32'h3FC, 32'd255, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the MIPS core. It owns the program counter, drives word addresses into the combinational instruction memory, and registers the returned word into the IF/ID stage register.
- It handles pipeline stall, branch/jump redirect, a boot delay while the instruction memory loads after reset, halt detection and an address-fault trap.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- MEM_WORDS, 256, number of instruction words; fetch word index must be < MEM_WORDS.
- BOOT_CYCLES, 4, cycles held in BOOT after reset deassertion before the first fetch (range 1..255).
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents this cycle.
- redirect_valid  in  1  branch/jump taken; load PC from redirect_pc.
- redirect_pc  in  32  byte-address redirect target.
- resume  in  1  leave HALTED and continue at the current PC.
- imem_addr  out  32  word index to instruction memory (pc >> 2).
- imem_instr  in  32  instruction word, combinational response to imem_addr.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  32  byte PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4.
- if_valid  out  1  IF/ID holds a real instruction; 0 means bubble.
- halted  out  1  state == HALTED.
- fault  out  1  sticky address fault.

Behaviour:
- Reset (async, any state, mid-operation included):
  - pc = RESET_PC; state = BOOT; boot counter = BOOT_CYCLES.
  - if_instr = 0, if_pc = 0, if_pc_plus4 = 0, if_valid = 0, halted = 0, fault = 0.
- imem_addr = {2'b00, pc[31:2]}, combinational, valid in every state. Fetch latency is 1 cycle: the word addressed in cycle N appears on if_instr after edge N.
- States: BOOT, RUN, HALTED, FAULT (2-bit encoding).
- BOOT:
  - Counter decrements each cycle; PC held; if_valid = 0.
  - At counter == 1, go to RUN. The first valid fetch is registered on the edge after entering RUN.
  - Inputs stall, redirect_valid and resume are ignored.
- RUN, priority order redirect_valid > stall > normal:
  - Normal: IF/ID <= {imem_instr, pc, pc+4}, if_valid <= 1, pc <= pc+4 (32-bit wrap, no carry out).
  - Stall: pc and all IF/ID outputs hold, including if_valid.
  - Redirect (also when stall is asserted in the same cycle): pc <= redirect_pc; if_valid <= 0 (flush); if_instr, if_pc and if_pc_plus4 hold.
  - Redirect check: if redirect_pc[1:0] != 0 or redirect_pc[31:2] >= MEM_WORDS, go to FAULT instead of loading pc; pc holds.
  - Sequential check: if a normal step would set pc[31:2] to a value >= MEM_WORDS, the current word is still latched (if_valid = 1), then go to FAULT; pc holds.
  - Halt: when a normal latch captures imem_instr == HALT_WORD, the word is latched with if_valid = 1, pc advances by 4, and the state becomes HALTED.
- HALTED:
  - pc and IF/ID data hold; if_valid <= 0 on the first HALTED edge.
  - redirect_valid: apply the redirect rules above (including fault checks); on success go to RUN.
  - Otherwise resume: go to RUN at the current pc.
  - redirect_valid takes priority over resume.
- FAULT:
  - fault = 1; if_valid = 0; pc holds; all inputs ignored.
  - Left only via rst.
- Output relations: halted = (state == HALTED); fault = (state == FAULT). Both are registered state decodes with no combinational path from inputs.

Decomposition:
- Shared package:
  - state enum localparams: ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALTED = 2'd2, ST_FAULT = 2'd3.
  - INSTR_W = 32, HALT_WORD default, PC_STEP = 4.
- One natural sub-module: if_id_reg, holding the IF/ID register (instr, pc, pc_plus4, valid) with load, hold and flush controls.
- The PC, boot counter and FSM stay in the top module.

Test Plan:
- Boot and sequential fetch: rst pulse, BOOT_CYCLES = 4, memory word k = k.
  - if_valid stays 0 for 4 cycles.
  - Then if_pc = 0, 4, 8 with if_instr = 0, 1, 2 on consecutive cycles; imem_addr = 0, 1, 2, 3.
- Stall: assert stall for 3 cycles while if_pc = 8.
  - if_pc, if_instr and if_valid are held at 8, 2, 1; imem_addr is held at 3.
  - After release, if_pc = 12.
- Redirect with simultaneous stall: redirect_valid = 1, redirect_pc = 0x40, stall = 1.
  - Next cycle if_valid = 0 and imem_addr = 0x10.
  - The following cycle if_pc = 0x40 with if_valid = 1.
- Halt and resume: word 5 = 32'hFFFF_FFFF.
  - if_pc = 20 is latched valid; halted = 1 next cycle; if_valid = 0; pc = 24.
  - resume gives if_pc = 24 valid.
- Faults:
  - redirect_pc = 0x42 gives fault = 1 the next cycle and if_valid = 0. fault stays 1 under redirect, resume and stall, and clears only on rst.
  - Separately, sequential fetch past word 255 gives word 255 valid, then fault = 1.
- Async reset mid-RUN: assert rst between clock edges.
  - Outputs clear immediately: if_valid = 0, halted = 0, fault = 0, imem_addr = RESET_PC >> 2.
  - BOOT then restarts.
